unsigned_radix_divider: RTL
===========================

// Module: unsigned_radix_divider
// PURPOSE
//  Iterative unsigned integer divider, the parametrised successor of the fixed radix-2 divider behind
//  the requester/divider handshake (start, dividend, divisor -> quotient, remainder, done, divisor_is_zero).
//  Width and bits-retired-per-cycle are generic. Adds busy/ready status, a flush abort, and
//  single-cycle fast paths. Sits inside the div unit, between the issue logic and the writeback port.
// PARAMETERS
//  DATA_WIDTH       32  operand/result width; must be >= 2
//  BITS_PER_CYCLE    2  quotient bits retired per RUN cycle; one of 1,2,4,8; DATA_WIDTH % BITS_PER_CYCLE == 0
//  FAST_PATHS        1  1: divide-by-zero and dividend<divisor complete in 1 cycle; 0: always full latency
// PORTS
//  clk              in   1           clock, all state on rising edge
//  rst              in   1           asynchronous, active-low reset
//  start            in   1           request; sampled only when ready=1
//  flush            in   1           abort in-flight division
//  dividend         in   DATA_WIDTH  sampled with start
//  divisor          in   DATA_WIDTH  sampled with start
//  ready            out  1           1 in IDLE or DONE (can accept start)
//  busy             out  1           1 in RUN
//  done             out  1           one-cycle pulse, results valid
//  quotient         out  DATA_WIDTH  held from done until next accepted start
//  remainder        out  DATA_WIDTH  held from done until next accepted start
//  divisor_is_zero  out  1           qualifies the current quotient/remainder
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; done=0, busy=0, ready=1, quotient=0, remainder=0, divisor_is_zero=0.
//  States: IDLE, RUN, DONE. N = DATA_WIDTH/BITS_PER_CYCLE.
//   IDLE/DONE + start & !flush: latch operands; zero/fast check -> DONE, else -> RUN with count=N-1.
//   IDLE/DONE, no start: DONE -> IDLE; IDLE stays.
//   RUN: each cycle shifts BITS_PER_CYCLE dividend bits into partial remainder, performs BITS_PER_CYCLE
//        chained restoring compare/subtract steps, appends quotient bits; count==0 -> DONE, else count-1.
//  Latency: start in cycle t -> done in cycle t+N+1 (DW=32,BPC=2: t+17). Fast path: done in t+1.
//  Back-to-back: start accepted in the DONE cycle; next done no earlier than N+1 later.
//  start while busy=1: ignored, no state change, no queueing.
//  Divisor==0: quotient=all ones, remainder=dividend, divisor_is_zero=1 (RISC-V semantics), with or
//   without FAST_PATHS (FAST_PATHS=0: computed result identical, at full latency).
//  Dividend<divisor (FAST_PATHS=1): quotient=0, remainder=dividend, divisor_is_zero=0.
//  flush: any state -> IDLE next edge; done suppressed; flush and start same cycle: flush wins, start dropped.
//   quotient/remainder/divisor_is_zero keep prior values after flush.
//  Partial remainder held DATA_WIDTH+1 bits wide; no overflow for dividend=all ones, divisor=1.
//  Async reset mid-RUN: immediate return to IDLE and reset values; no done.
//  Outputs quotient/remainder are registers, not combinational from RUN datapath.
// STRUCTURE
//  Package taiga_types: div_state_t enum {DIV_IDLE, DIV_RUN, DIV_DONE}; package taiga_config:
//   DIV_BITS_PER_CYCLE default constant used at instantiation.
//  Sub-module div_radix_step: purely combinational, BITS_PER_CYCLE chained restoring steps
//   (in: partial remainder, dividend bits, divisor; out: next remainder, quotient bits).
//  Top: FSM, iteration counter ($clog2(N) bits), operand/result registers, fast-path compare.
// TESTING
//  DW=32,BPC=2: 100/7 start at t -> done only at t+17, quotient=14, remainder=2, divisor_is_zero=0.
//  Divisor 0, dividend 0x1234_5678 -> done t+1, quotient=0xFFFF_FFFF, remainder=0x1234_5678, dbz=1.
//  0xFFFF_FFFF/1 on BPC=1,2,4,8 -> quotient=0xFFFF_FFFF, remainder=0; latency 33/17/9/5 cycles.
//  Start 50/3 then start again at done cycle with 9/4 -> done pulses give 16r2 then 2r1, no gap lost.
//  Flush at RUN cycle 5 of 1000/3 -> no done; outputs retain previous result; ready=1 next cycle.
//  start while busy (20/6) ignored; async rst pulse mid-RUN -> all outputs reset values, no done.

Source files
------------

// File: rtl/unsigned_radix_divider_pkg.sv
// Shared types and defaults for the unsigned radix divider.
//   div_state_t        : controller states (idle, iterating, result valid)
//   DIV_DATA_WIDTH     : default operand/result width
//   DIV_BITS_PER_CYCLE : default quotient bits retired per iteration cycle
//   cnt_width()        : iteration counter width, never narrower than 1 bit
package unsigned_radix_divider_pkg;

  localparam int DIV_DATA_WIDTH     = 32;
  localparam int DIV_BITS_PER_CYCLE = 2;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

  // A single-iteration configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unsigned_radix_divider_if.sv
// Requester/divider handshake bundle.
//   master : requester side, drives start/flush/operands, sees status and results
//   slave  : divider side
interface unsigned_radix_divider_if
  import unsigned_radix_divider_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) ();

  logic                  start;
  logic                  flush;
  logic [DATA_WIDTH-1:0] dividend;
  logic [DATA_WIDTH-1:0] divisor;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] quotient;
  logic [DATA_WIDTH-1:0] remainder;
  logic                  divisor_is_zero;

  modport master (
    output start, flush, dividend, divisor,
    input  ready, busy, done, quotient, remainder, divisor_is_zero
  );

  modport slave (
    input  start, flush, dividend, divisor,
    output ready, busy, done, quotient, remainder, divisor_is_zero
  );

endinterface

// File: rtl/unsigned_radix_divider_div_radix_step.sv
// Combinational block of BITS_PER_CYCLE chained restoring division steps.
//   rem_in   : partial remainder entering this cycle (always < divisor)
//   dvd_bits : next dividend bits, MSB consumed first
//   divisor  : divisor operand
//   rem_out  : partial remainder after all steps
//   q_bits   : quotient bits produced, MSB first
module div_radix_step
  import unsigned_radix_divider_pkg::*;
#(
  parameter int DATA_WIDTH     = DIV_DATA_WIDTH,
  parameter int BITS_PER_CYCLE = DIV_BITS_PER_CYCLE
) (
  input  logic [DATA_WIDTH-1:0]     rem_in,
  input  logic [BITS_PER_CYCLE-1:0] dvd_bits,
  input  logic [DATA_WIDTH-1:0]     divisor,
  output logic [DATA_WIDTH-1:0]     rem_out,
  output logic [BITS_PER_CYCLE-1:0] q_bits
);

  // One extra bit so the shifted remainder can exceed 2^DATA_WIDTH-1
  // (e.g. all-ones dividend over a large divisor) without wrapping.
  logic [DATA_WIDTH:0] r;

  always_comb begin
    r      = {1'b0, rem_in};
    q_bits = '0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      r = {r[DATA_WIDTH-1:0], dvd_bits[i]};
      if (r >= {1'b0, divisor}) begin
        r         = r - {1'b0, divisor};
        q_bits[i] = 1'b1;
      end
    end
    rem_out = r[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/unsigned_radix_divider.sv
// Iterative unsigned divider retiring BITS_PER_CYCLE quotient bits per cycle.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active low
//   bus  : slave side of the handshake (start/flush/operands in;
//          ready/busy/done/quotient/remainder/divisor_is_zero out)
// Divide by zero yields all-ones quotient and remainder = dividend.
// Results are registered and only change on a completed division.
module unsigned_radix_divider
  import unsigned_radix_divider_pkg::*;
#(
  parameter int DATA_WIDTH     = DIV_DATA_WIDTH,
  parameter int BITS_PER_CYCLE = DIV_BITS_PER_CYCLE,
  parameter bit FAST_PATHS     = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  unsigned_radix_divider_if.slave bus
);

  localparam int               N        = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int               CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);

  div_state_t state_q, state_d;

  logic [CNT_W-1:0]          cnt_q;
  logic [DATA_WIDTH-1:0]     dq_q;       // dividend shifts out the top, quotient fills the bottom
  logic [DATA_WIDTH-1:0]     dsr_q;
  logic [DATA_WIDTH-1:0]     rem_q;
  logic [DATA_WIDTH-1:0]     quo_out_q;
  logic [DATA_WIDTH-1:0]     rem_out_q;
  logic                      dbz_out_q;

  logic                      accept;
  logic                      fast;
  logic                      step_en;
  logic                      finish;
  logic [DATA_WIDTH-1:0]     rem_next;
  logic [DATA_WIDTH-1:0]     dq_next;
  logic [BITS_PER_CYCLE-1:0] q_bits;

  div_radix_step #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_in   (rem_q),
    .dvd_bits (dq_q[DATA_WIDTH-1 -: BITS_PER_CYCLE]),
    .divisor  (dsr_q),
    .rem_out  (rem_next),
    .q_bits   (q_bits)
  );

  assign dq_next = (dq_q << BITS_PER_CYCLE) | DATA_WIDTH'(q_bits);

  assign fast = FAST_PATHS && ((bus.divisor == '0) || (bus.dividend < bus.divisor));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DIV_IDLE;
    else      state_q <= state_d;
  end

  // flush dominates everything, including a same-cycle start.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step_en = 1'b0;
    finish  = 1'b0;
    case (state_q)
      DIV_IDLE, DIV_DONE: begin
        if (bus.flush) begin
          state_d = DIV_IDLE;
        end else if (bus.start) begin
          accept  = 1'b1;
          state_d = fast ? DIV_DONE : DIV_RUN;
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_RUN: begin
        if (bus.flush) begin
          state_d = DIV_IDLE;
        end else begin
          step_en = 1'b1;
          if (cnt_q == '0) begin
            finish  = 1'b1;
            state_d = DIV_DONE;
          end
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      dq_q      <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
    end else if (accept) begin
      dq_q  <= bus.dividend;
      dsr_q <= bus.divisor;
      rem_q <= '0;
      cnt_q <= CNT_LOAD;
      if (fast) begin
        quo_out_q <= (bus.divisor == '0) ? '1 : '0;
        rem_out_q <= bus.dividend;
        dbz_out_q <= (bus.divisor == '0);
      end
    end else if (step_en) begin
      dq_q  <= dq_next;
      rem_q <= rem_next;
      cnt_q <= cnt_q - CNT_W'(1);
      if (finish) begin
        quo_out_q <= dq_next;
        rem_out_q <= rem_next;
        dbz_out_q <= (dsr_q == '0);
      end
    end
  end

  assign bus.ready           = (state_q == DIV_IDLE) || (state_q == DIV_DONE);
  assign bus.busy            = (state_q == DIV_RUN);
  assign bus.done            = (state_q == DIV_DONE);
  assign bus.quotient        = quo_out_q;
  assign bus.remainder       = rem_out_q;
  assign bus.divisor_is_zero = dbz_out_q;

endmodule
